// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches opcode (+ optional target byte)
// over a req/ack handshake and resolves JMP/CALL/RET/JZ/JNZ via a return stack.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for ir_load
// S_FETCH_OP  | requesting opcode byte at pc
// S_FETCH_IMM | requesting immediate/target byte at pc
// S_READY     | ir/opr valid, waiting for a branch or pc_load from control
module fetch_unit #(
  parameter int          ADDR_W      = 8,
  parameter int unsigned RESET_PC    = 0,
  parameter int          STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic              br_jmp,
  input  logic              br_call,
  input  logic              br_ret,
  input  logic              br_jz,
  input  logic              br_jnz,
  input  logic              zero_flag,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        ir,
  output logic [7:0]        opr,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              busy,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH_OP  = 2'd1,
    S_FETCH_IMM = 2'd2,
    S_READY     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        opr_q, opr_d;
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              two_byte;

  always_comb begin
    case (imem_rdata)
      8'h81, 8'h82, 8'h84, 8'h85, 8'h87: two_byte = 1'b1;
      default:                           two_byte = 1'b0;
    endcase
  end

  assign sp_m1 = sp_q - SP_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        if (ir_load) state_d = S_FETCH_OP;
      end
      S_FETCH_OP: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = two_byte ? S_FETCH_IMM : S_READY;
        end
      end
      S_FETCH_IMM: begin
        if (imem_ack) begin
          opr_d   = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_READY;
        end
      end
      S_READY: begin
        // ret > call > jmp > jz > jnz > pc_load
        if (br_ret) begin
          if (sp_q == '0) begin
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[sp_m1[IDX_W-1:0]];
            sp_d = sp_m1;
          end
          state_d = S_IDLE;
        end else if (br_call) begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[sp_q[IDX_W-1:0]] = pc_q;
            sp_d = sp_q + SP_W'(1);
            pc_d = ADDR_W'(opr_q);
          end
          state_d = S_IDLE;
        end else if (br_jmp) begin
          pc_d    = ADDR_W'(opr_q);
          state_d = S_IDLE;
        end else if (br_jz) begin
          if (zero_flag) pc_d = ADDR_W'(opr_q);
          state_d = S_IDLE;
        end else if (br_jnz) begin
          if (!zero_flag) pc_d = ADDR_W'(opr_q);
          state_d = S_IDLE;
        end else if (pc_load) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      opr_q   <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH_OP) || (state_q == S_FETCH_IMM);
  assign busy      = imem_req;
  assign ir_valid  = (state_q == S_READY);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opr       = opr_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural memory answers requests after a
// programmable latency; each step checks hand-computed PC/IR/OPR/flag values.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ir_load = 0, pc_load = 0;
  logic       br_jmp = 0, br_call = 0, br_ret = 0, br_jz = 0, br_jnz = 0;
  logic       zero_flag = 0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 0;
  logic [7:0] imem_rdata = 0;
  logic [7:0] ir, opr, pc;
  logic       ir_valid, busy, stack_ovf, stack_unf;

  logic [7:0] mem [256];
  int         lat = 1;
  int         wait_cnt = 0;
  bit         mem_en = 1;
  int         checks = 0;
  int         errors = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(0), .STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .ir_load(ir_load), .pc_load(pc_load),
    .br_jmp(br_jmp), .br_call(br_call), .br_ret(br_ret),
    .br_jz(br_jz), .br_jnz(br_jnz), .zero_flag(zero_flag),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opr(opr), .pc(pc),
    .ir_valid(ir_valid), .busy(busy),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clock = ~clock;

  // Memory responder: ack lands in the lat-th consecutive request cycle.
  always @(negedge clock) begin
    if (mem_en) begin
      imem_ack = 1'b0;
      if (imem_req) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    int n;
    ir_load = 1;
    tick();
    ir_load = 0;
    n = 0;
    while (!ir_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 16'(ir_valid), 16'd1);
  endtask

  task automatic do_reset();
    reset = 0;
    #3;
    reset = 1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h81; mem[8'h02] = 8'h20;
    mem[8'h20] = 8'h81; mem[8'h21] = 8'h10;
    mem[8'h10] = 8'h84; mem[8'h11] = 8'h40;
    mem[8'h40] = 8'h03;
    mem[8'h12] = 8'h03;

    // reset values
    #2;
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_valid", 16'(ir_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pc", 16'(pc), 16'h00);
    chk("rst_ir", 16'(ir), 16'h00);
    chk("rst_opr", 16'(opr), 16'h00);
    chk("rst_ovf", 16'(stack_ovf), 16'd0);
    chk("rst_unf", 16'(stack_unf), 16'd0);
    reset = 1;
    tick();

    // one-byte fetch, zero-wait memory
    lat = 1;
    ir_load = 1;
    tick();
    ir_load = 0;
    chk("t1_req", 16'(imem_req), 16'd1);
    chk("t1_busy", 16'(busy), 16'd1);
    chk("t1_addr", 16'(imem_addr), 16'h00);
    tick();
    chk("t1_valid", 16'(ir_valid), 16'd1);
    chk("t1_ir", 16'(ir), 16'h01);
    chk("t1_pc", 16'(pc), 16'h01);
    chk("t1_opr", 16'(opr), 16'h00);
    pc_load = 1; tick(); pc_load = 0;
    chk("t1_retire_valid", 16'(ir_valid), 16'd0);
    chk("t1_retire_pc", 16'(pc), 16'h01);

    // two-byte JMP with 3-cycle latency per byte
    lat = 3;
    ir_load = 1;
    tick();
    ir_load = 0;
    chk("t2_addr1", 16'(imem_addr), 16'h01);
    tick(); tick(); tick();
    chk("t2_ir", 16'(ir), 16'h81);
    chk("t2_pc_mid", 16'(pc), 16'h02);
    chk("t2_req_byte2", 16'(imem_req), 16'd1);
    chk("t2_addr2", 16'(imem_addr), 16'h02);
    tick(); tick();
    chk("t2_not_ready", 16'(ir_valid), 16'd0);
    tick();
    chk("t2_valid", 16'(ir_valid), 16'd1);
    chk("t2_opr", 16'(opr), 16'h20);
    chk("t2_pc", 16'(pc), 16'h03);
    br_jmp = 1; tick(); br_jmp = 0;
    chk("t2_jmp_pc", 16'(pc), 16'h20);

    // JMP 0x10, CALL 0x40, RET back to 0x12, then RET on emptied stack
    lat = 1;
    fetch("t3_jmp");
    br_jmp = 1; tick(); br_jmp = 0;
    chk("t3_jmp_pc", 16'(pc), 16'h10);
    fetch("t3_call");
    chk("t3_call_pc", 16'(pc), 16'h12);
    chk("t3_call_opr", 16'(opr), 16'h40);
    br_call = 1; tick(); br_call = 0;
    chk("t3_called_pc", 16'(pc), 16'h40);
    fetch("t3_ret");
    chk("t3_ret_fetch_pc", 16'(pc), 16'h41);
    br_ret = 1; tick(); br_ret = 0;
    chk("t3_ret_pc", 16'(pc), 16'h12);
    chk("t3_ret_unf", 16'(stack_unf), 16'd0);
    fetch("t3_ret2");
    br_ret = 1; tick(); br_ret = 0;
    chk("t3_sp0_unf", 16'(stack_unf), 16'd1);
    chk("t3_sp0_pc", 16'(pc), 16'h13);

    // five nested calls into a four-deep stack
    do_reset();
    chk("t4_rst_unf", 16'(stack_unf), 16'd0);
    mem[8'h00] = 8'h84; mem[8'h01] = 8'h50;
    mem[8'h50] = 8'h84; mem[8'h51] = 8'h60;
    mem[8'h60] = 8'h84; mem[8'h61] = 8'h70;
    mem[8'h70] = 8'h84; mem[8'h71] = 8'h80;
    mem[8'h80] = 8'h84; mem[8'h81] = 8'h90;
    fetch("t4_c1"); br_call = 1; tick(); br_call = 0;
    chk("t4_c1_pc", 16'(pc), 16'h50);
    fetch("t4_c2"); br_call = 1; tick(); br_call = 0;
    chk("t4_c2_pc", 16'(pc), 16'h60);
    fetch("t4_c3"); br_call = 1; tick(); br_call = 0;
    chk("t4_c3_pc", 16'(pc), 16'h70);
    fetch("t4_c4"); br_call = 1; tick(); br_call = 0;
    chk("t4_c4_pc", 16'(pc), 16'h80);
    chk("t4_c4_ovf", 16'(stack_ovf), 16'd0);
    fetch("t4_c5"); br_call = 1; tick(); br_call = 0;
    chk("t4_c5_ovf", 16'(stack_ovf), 16'd1);
    chk("t4_c5_pc", 16'(pc), 16'h82);
    do_reset();
    chk("t4_rst_ovf", 16'(stack_ovf), 16'd0);
    fetch("t4_empty");
    br_ret = 1; tick(); br_ret = 0;
    chk("t4_empty_unf", 16'(stack_unf), 16'd1);
    chk("t4_empty_pc", 16'(pc), 16'h02);

    // JZ / JNZ, wrap at 0xFF, RET beats JMP
    do_reset();
    mem[8'h00] = 8'h85; mem[8'h01] = 8'h33;
    mem[8'h02] = 8'h85; mem[8'h03] = 8'h33;
    mem[8'h33] = 8'h87; mem[8'h34] = 8'h60;
    mem[8'h35] = 8'h87; mem[8'h36] = 8'hFF;
    mem[8'hFF] = 8'h01;
    zero_flag = 0;
    fetch("t5_jz0"); br_jz = 1; tick(); br_jz = 0;
    chk("t5_jz0_pc", 16'(pc), 16'h02);
    zero_flag = 1;
    fetch("t5_jz1"); br_jz = 1; tick(); br_jz = 0;
    chk("t5_jz1_pc", 16'(pc), 16'h33);
    fetch("t5_jnz1"); br_jnz = 1; tick(); br_jnz = 0;
    chk("t5_jnz1_pc", 16'(pc), 16'h35);
    zero_flag = 0;
    fetch("t5_jnz0"); br_jnz = 1; tick(); br_jnz = 0;
    chk("t5_jnz0_pc", 16'(pc), 16'hFF);
    fetch("t5_wrap");
    chk("t5_wrap_pc", 16'(pc), 16'h00);
    pc_load = 1; tick(); pc_load = 0;
    fetch("t5_prio");
    br_ret = 1; br_jmp = 1; tick(); br_ret = 0; br_jmp = 0;
    chk("t5_prio_pc", 16'(pc), 16'h02);
    chk("t5_prio_unf", 16'(stack_unf), 16'd1);

    // asynchronous reset in the middle of the immediate fetch
    do_reset();
    lat = 3;
    ir_load = 1; tick(); ir_load = 0;
    tick(); tick(); tick();
    chk("t6_in_imm_req", 16'(imem_req), 16'd1);
    chk("t6_in_imm_ir", 16'(ir), 16'h85);
    reset = 0;
    #1;
    chk("t6_async_req", 16'(imem_req), 16'd0);
    chk("t6_async_pc", 16'(pc), 16'h00);
    chk("t6_async_ir", 16'(ir), 16'h00);
    mem_en = 0;
    imem_ack = 0;
    tick();
    reset = 1;
    imem_ack = 1; imem_rdata = 8'h81;
    tick();
    imem_ack = 0;
    tick();
    chk("t6_stray_busy", 16'(busy), 16'd0);
    chk("t6_stray_valid", 16'(ir_valid), 16'd0);
    chk("t6_stray_ir", 16'(ir), 16'h00);
    chk("t6_stray_pc", 16'(pc), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the control unit: it owns the program counter, fetches opcode bytes (plus an immediate target byte for branch opcodes) from instruction memory over a req/ack handshake, and presents `ir`/`opr` to the control unit. It also executes the control-flow decisions the control unit signals (JMP/GOTO, CALL, RET, JZ, JNZ) using an internal return-address stack.

## Interface
- `ADDR_W`, 8: PC / memory address width.
- `RESET_PC`, 0: PC value after reset.
- `STACK_DEPTH`, 4: return-address stack entries (power of two, ≥2).
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `ir_load` in 1: start a fetch; accepted only in IDLE.
- `pc_load` in 1: retire current non-branch instruction; accepted only in READY.
- `br_jmp`, `br_call`, `br_ret`, `br_jz`, `br_jnz` in 1 each: branch pulses from the control unit; accepted only in READY.
- `zero_flag` in 1: ALU zero flag, sampled with `br_jz`/`br_jnz`.
- `imem_req` out 1: memory request, held until ack.
- `imem_addr` out ADDR_W: equals `pc` while `imem_req`=1.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 8: fetched byte.
- `ir` out 8: opcode register.
- `opr` out 8: immediate/target register.
- `pc` out ADDR_W: address of next byte to fetch.
- `ir_valid` out 1: high in READY.
- `busy` out 1: high in FETCH_OP or FETCH_IMM.
- `stack_ovf`, `stack_unf` out 1 each: sticky error flags.

## Operation
- States: IDLE, FETCH_OP, FETCH_IMM, READY.
- IDLE: `ir_load`=1 → FETCH_OP.
- FETCH_OP: `imem_req`=1. On `imem_ack`: `ir`←rdata, `pc`←pc+1; if rdata ∈ {0x81, 0x82, 0x84, 0x85, 0x87} → FETCH_IMM, else → READY.
- FETCH_IMM: `imem_req`=1. On ack: `opr`←rdata, `pc`←pc+1, → READY. `opr` is not modified by one-byte opcodes.
- READY: inputs are evaluated with priority ret > call > jmp > jz > jnz > pc_load. The highest-priority asserted input acts and the FSM → IDLE.
  - jmp: `pc`←`opr`.
  - jz: `pc`←`opr` if `zero_flag`=1; otherwise `pc` unchanged.
  - jnz: `pc`←`opr` if `zero_flag`=0; otherwise `pc` unchanged.
  - call: push `pc` (return address, already past the immediate), then `pc`←`opr`. If the stack is full: no push, no jump, `stack_ovf`←1.
  - ret: pop into `pc`. If the stack is empty: `pc` unchanged, `stack_unf`←1.
  - pc_load: no PC change.
- Ignored inputs:
  - `ir_load` outside IDLE.
  - Branch inputs and `pc_load` outside READY.
  - `imem_ack` outside the FETCH states.
- Width and stack rules:
  - PC arithmetic is modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00.
  - Stack pointer `sp` ranges 0..STACK_DEPTH.
  - Error flags are cleared only by reset.
- Reset (asynchronous, any state, including mid-fetch), effective immediately:
  - `pc`=RESET_PC; `ir`=0, `opr`=0; `sp`=0; state=IDLE.
  - `imem_req`=0, `ir_valid`=0, `busy`=0, `stack_ovf`=0, `stack_unf`=0.

## Timing
- `ir_load` at edge N → `imem_req`=1 during cycle N+1.
- Ack in cycle k → `ir`, `pc`, and the state update at edge k.
  - One-byte instruction with zero-wait memory (ack in the first request cycle): `ir_valid`=1 two cycles after `ir_load`.
  - Each additional wait cycle adds one cycle; a two-byte instruction adds one full handshake.
- `imem_addr` is stable for the whole request. A new request for byte 2 starts in the cycle after the byte-1 ack (`imem_req` may stay high continuously).
- Branch/retire at edge R → `pc` updated and `ir_valid`=0 from R. Earliest next `ir_load` is accepted at edge R+1.
- Outputs are registered except `imem_req`, `imem_addr`, `ir_valid` and `busy`, which decode state/`pc`.

## Test plan
- Reset; mem[0]=0x01, ack latency 1; pulse `ir_load` → `ir`=0x01, `pc`=1, `ir_valid`=1 two cycles later, `opr`=0; `pc_load` → IDLE, `pc` stays 1.
- mem[1]=0x81, mem[2]=0x20, ack latency 3 each → `imem_addr` 1 then 2, `ir`=0x81, `opr`=0x20, `pc`=3; `br_jmp` → `pc`=0x20.
- CALL 0x40 at address 0x10 → `pc`=0x12 after fetch, push 0x12, `pc`=0x40; then RET fetched at 0x40 with `br_ret` → `pc`=0x12, `sp`=0.
- Five nested CALLs with STACK_DEPTH=4 → fifth sets `stack_ovf`=1 and `pc` stays at its return address; reset, then RET with empty stack → `stack_unf`=1, `pc` unchanged.
- JZ 0x33 with `zero_flag`=0 → `pc`=fetch addr+2; repeat with `zero_flag`=1 → `pc`=0x33; simultaneous `br_ret`+`br_jmp` → RET wins. `pc`=0xFF one-byte fetch → `pc` wraps to 0x00.
- Assert `reset` low mid-FETCH_IMM with `imem_req`=1 → `imem_req`=0 immediately, `pc`=0, `ir`=0; an ack arriving after reset release is ignored, state stays IDLE.
